sr_ff_bank: RTL and testbench

//  WIDTH-bit bank of independently enabled two-input flip-flops. A run-time

---
 rtl/sr_ff_bank.sv | 91 +++++++++
 tb/tb_sr_ff_bank.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sr_ff_bank.sv
// WIDTH-bit bank of enabled SR/JK/D/T flip-flops with sticky SR-illegal flags and a saturating error count.
// Latency: one cycle from input sample to q. Backpressure: none, every edge updates every enabled bit.
module sr_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RST_VAL   = '0,
  parameter int               SR_POLICY = 0,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] err_flag,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] ill;
  logic             any_ill;

  always_comb begin
    q_nxt = q;
    ill   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (en[i]) begin
        case (mode)
          MODE_SR: begin
            case ({a[i], b[i]})
              2'b01:   q_nxt[i] = 1'b0;
              2'b10:   q_nxt[i] = 1'b1;
              2'b11: begin
                ill[i] = 1'b1;
                // S=R=1 resolves to a defined value, never X
                case (SR_POLICY)
                  1:       q_nxt[i] = 1'b1;
                  2:       q_nxt[i] = 1'b0;
                  3:       q_nxt[i] = ~q[i];
                  default: q_nxt[i] = q[i];
                endcase
              end
              default: q_nxt[i] = q[i];
            endcase
          end
          MODE_JK: begin
            case ({a[i], b[i]})
              2'b01:   q_nxt[i] = 1'b0;
              2'b10:   q_nxt[i] = 1'b1;
              2'b11:   q_nxt[i] = ~q[i];
              default: q_nxt[i] = q[i];
            endcase
          end
          MODE_D:  q_nxt[i] = a[i];
          MODE_T:  q_nxt[i] = a[i] ? ~q[i] : q[i];
          default: q_nxt[i] = q[i];
        endcase
      end
    end
  end

  assign any_ill = |ill;
  assign qb      = ~q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= RST_VAL;
      err_flag <= '0;
      err_cnt  <= '0;
    end else begin
      q <= q_nxt;
      if (err_clr) begin
        err_flag <= ill;
        err_cnt  <= CNT_W'(any_ill);
      end else begin
        err_flag <= err_flag | ill;
        if (any_ill && (err_cnt != {CNT_W{1'b1}}))
          err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed bench for sr_ff_bank: a hold-policy instance plus a toggle-policy instance on shared inputs.
module tb_sr_ff_bank;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic [7:0] en, a, b;
  logic       err_clr;
  logic [7:0] q, qb, err_flag, err_cnt;
  logic [7:0] q2, qb2, err_flag2, err_cnt2;

  int n_chk  = 0;
  int n_fail = 0;

  sr_ff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .SR_POLICY(0), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .a(a), .b(b), .err_clr(err_clr),
    .q(q), .qb(qb), .err_flag(err_flag), .err_cnt(err_cnt)
  );

  sr_ff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .SR_POLICY(3), .CNT_W(8)) u_dut_tgl (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .a(a), .b(b), .err_clr(err_clr),
    .q(q2), .qb(qb2), .err_flag(err_flag2), .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2'b00; en = 8'h00; a = 8'h00; b = 8'h00; err_clr = 1'b0;
    step();
    rst = 1'b0;
    n_chk++; if (q !== 8'hA5) begin n_fail++; $display("FAIL reset_q got=%h exp=%h", q, 8'hA5); end
    n_chk++; if (qb !== 8'h5A) begin n_fail++; $display("FAIL reset_qb got=%h exp=%h", qb, 8'h5A); end
    n_chk++; if (err_flag !== 8'h00) begin n_fail++; $display("FAIL reset_flag got=%h exp=%h", err_flag, 8'h00); end
    n_chk++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=%0d", err_cnt, 0); end
  endtask

  task automatic test_sr();
    mode = 2'b00; en = 8'hFF; a = 8'h0F; b = 8'hF0;
    step();
    n_chk++; if (q !== 8'h0F) begin n_fail++; $display("FAIL sr_setclr_q got=%h exp=%h", q, 8'h0F); end
    n_chk++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL sr_setclr_cnt got=%0d exp=%0d", err_cnt, 0); end
    a = 8'h01; b = 8'h01;
    step();
    n_chk++; if (q !== 8'h0F) begin n_fail++; $display("FAIL sr_ill_hold_q got=%h exp=%h", q, 8'h0F); end
    n_chk++; if (err_flag !== 8'h01) begin n_fail++; $display("FAIL sr_ill_flag got=%h exp=%h", err_flag, 8'h01); end
    n_chk++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL sr_ill_cnt got=%0d exp=%0d", err_cnt, 1); end
    n_chk++; if (q2 !== 8'h0E) begin n_fail++; $display("FAIL sr_ill_toggle_q got=%h exp=%h", q2, 8'h0E); end
    n_chk++; if (err_cnt2 !== 8'd1) begin n_fail++; $display("FAIL sr_ill_toggle_cnt got=%0d exp=%0d", err_cnt2, 1); end
    a = 8'h00; b = 8'h00;
    step();
    n_chk++; if (q !== 8'h0F) begin n_fail++; $display("FAIL sr_hold_q got=%h exp=%h", q, 8'h0F); end
    n_chk++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL sr_hold_cnt got=%0d exp=%0d", err_cnt, 1); end
    n_chk++; if (err_flag !== 8'h01) begin n_fail++; $display("FAIL sr_sticky_flag got=%h exp=%h", err_flag, 8'h01); end
  endtask

  task automatic test_jk();
    mode = 2'b01; en = 8'hF0; a = 8'hFF; b = 8'hFF;
    step();
    n_chk++; if (q !== 8'hFF) begin n_fail++; $display("FAIL jk_toggle_q got=%h exp=%h", q, 8'hFF); end
    n_chk++; if (q2 !== 8'hFE) begin n_fail++; $display("FAIL jk_toggle_q2 got=%h exp=%h", q2, 8'hFE); end
    n_chk++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL jk_no_err_cnt got=%0d exp=%0d", err_cnt, 1); end
    n_chk++; if (err_flag !== 8'h01) begin n_fail++; $display("FAIL jk_no_err_flag got=%h exp=%h", err_flag, 8'h01); end
    en = 8'hFF; a = 8'h0F; b = 8'hF0;
    step();
    n_chk++; if (q !== 8'h0F) begin n_fail++; $display("FAIL jk_setclr_q got=%h exp=%h", q, 8'h0F); end
    a = 8'h00; b = 8'h00;
    step();
    n_chk++; if (q !== 8'h0F) begin n_fail++; $display("FAIL jk_hold_q got=%h exp=%h", q, 8'h0F); end
  endtask

  task automatic test_d_t();
    mode = 2'b10; en = 8'hFF; a = 8'h3C; b = 8'hFF;
    step();
    n_chk++; if (q !== 8'h3C) begin n_fail++; $display("FAIL d_q got=%h exp=%h", q, 8'h3C); end
    n_chk++; if (qb !== 8'hC3) begin n_fail++; $display("FAIL d_qb got=%h exp=%h", qb, 8'hC3); end
    n_chk++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL d_no_err_cnt got=%0d exp=%0d", err_cnt, 1); end
    mode = 2'b11; a = 8'hFF;
    step();
    n_chk++; if (q !== 8'hC3) begin n_fail++; $display("FAIL t_first_q got=%h exp=%h", q, 8'hC3); end
    step();
    n_chk++; if (q !== 8'h3C) begin n_fail++; $display("FAIL t_second_q got=%h exp=%h", q, 8'h3C); end
    en = 8'h0F;
    step();
    n_chk++; if (q !== 8'h33) begin n_fail++; $display("FAIL t_masked_q got=%h exp=%h", q, 8'h33); end
    mode = 2'b00; en = 8'h00; a = 8'hFF; b = 8'hFF;
    step();
    n_chk++; if (q !== 8'h33) begin n_fail++; $display("FAIL sr_disabled_q got=%h exp=%h", q, 8'h33); end
    n_chk++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL sr_disabled_cnt got=%0d exp=%0d", err_cnt, 1); end
    n_chk++; if (err_flag !== 8'h01) begin n_fail++; $display("FAIL sr_disabled_flag got=%h exp=%h", err_flag, 8'h01); end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    mode = 2'b00; en = 8'hFF; a = 8'h00; b = 8'h00; err_clr = 1'b1;
    step();
    n_chk++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_idle_cnt got=%0d exp=%0d", err_cnt, 0); end
    n_chk++; if (err_flag !== 8'h00) begin n_fail++; $display("FAIL clr_idle_flag got=%h exp=%h", err_flag, 8'h00); end
    err_clr = 1'b0; a = 8'h01; b = 8'h01;
    for (int i = 1; i <= 300; i++) begin
      step();
      exp_cnt = (i > 255) ? 255 : i;
      n_chk++;
      if (err_cnt !== 8'(exp_cnt)) begin
        n_fail++; $display("FAIL sat_cnt cycle=%0d got=%0d exp=%0d", i, err_cnt, exp_cnt);
      end
    end
    n_chk++; if (err_cnt2 !== 8'd255) begin n_fail++; $display("FAIL sat_cnt2 got=%0d exp=%0d", err_cnt2, 255); end
    err_clr = 1'b1;
    step();
    n_chk++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL clr_ill_cnt got=%0d exp=%0d", err_cnt, 1); end
    n_chk++; if (err_flag !== 8'h01) begin n_fail++; $display("FAIL clr_ill_flag got=%h exp=%h", err_flag, 8'h01); end
    err_clr = 1'b0; a = 8'h02; b = 8'h02;
    step();
    n_chk++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL post_clr_cnt got=%0d exp=%0d", err_cnt, 2); end
    n_chk++; if (err_flag !== 8'h03) begin n_fail++; $display("FAIL post_clr_flag got=%h exp=%h", err_flag, 8'h03); end
  endtask

  task automatic test_reset_mid();
    mode = 2'b00; en = 8'hFF; a = 8'hFF; b = 8'hFF; rst = 1'b1;
    step();
    n_chk++; if (q !== 8'hA5) begin n_fail++; $display("FAIL midrst_q got=%h exp=%h", q, 8'hA5); end
    n_chk++; if (err_flag !== 8'h00) begin n_fail++; $display("FAIL midrst_flag got=%h exp=%h", err_flag, 8'h00); end
    n_chk++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_cnt got=%0d exp=%0d", err_cnt, 0); end
    n_chk++; if (q2 !== 8'hA5) begin n_fail++; $display("FAIL midrst_q2 got=%h exp=%h", q2, 8'hA5); end
    rst = 1'b0;
    step();
    n_chk++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL after_rst_cnt got=%0d exp=%0d", err_cnt, 1); end
    n_chk++; if (err_flag !== 8'hFF) begin n_fail++; $display("FAIL after_rst_flag got=%h exp=%h", err_flag, 8'hFF); end
    n_chk++; if (q !== 8'hA5) begin n_fail++; $display("FAIL after_rst_q got=%h exp=%h", q, 8'hA5); end
    n_chk++; if (q2 !== 8'h5A) begin n_fail++; $display("FAIL after_rst_q2 got=%h exp=%h", q2, 8'h5A); end
  endtask

  initial begin
    test_reset();
    test_sr();
    test_jk();
    test_d_t();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
